// File: rtl/periodic_tick_counter_pkg.sv
// rtl/periodic_tick_counter_pkg.sv - shared types and constants for the periodic tick counter
package periodic_tick_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } tick_state_t;

    localparam logic [7:0] ASCII_ZERO        = 8'h30;
    localparam logic [7:0] DEFAULT_TICK_CHAR = 8'h50;

    function automatic logic [3:0] digit_next(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/periodic_tick_counter_uart_req_slot.sv
// rtl/periodic_tick_counter_uart_req_slot.sv - one-entry valid/ready byte holding register with overrun flag
module uart_req_slot
    import periodic_tick_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    input  logic       i_clear_ovr,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_overrun
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_overrun;
    logic       w_accept;

    assign w_accept = r_valid & i_ready;

    // A load in the acceptance cycle refills the slot with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_load && (!r_valid || w_accept)) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (i_clear_ovr) begin
            r_overrun <= 1'b0;
        end else if (i_load && r_valid && !w_accept) begin
            r_overrun <= 1'b1;
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/periodic_tick_counter.sv
// rtl/periodic_tick_counter.sv - programmable-period tick counter with UART byte request per tick
// Optional ASCII digit payload selected by macro PERIODIC_TICK_ASCII_EN.
module periodic_tick_counter
    import periodic_tick_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [63:0] PERIOD    = 64'd1000000000,
    parameter int          TICK_W    = 16,
    parameter logic [7:0]  TICK_CHAR = DEFAULT_TICK_CHAR
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_oneshot,
    input  logic              i_clear,
    output logic [WIDTH-1:0]  o_count,
    output logic              o_tick,
    output logic [TICK_W-1:0] o_tick_count,
    output logic              o_start_uart,
    input  logic              i_uart_ready,
    output logic [7:0]        o_uart_data,
    output logic              o_overrun
);

    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(PERIOD - 64'd1);

    tick_state_t       r_state;
    tick_state_t       w_state_nxt;
    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  w_count_nxt;
    logic              r_tick;
    logic              w_wrap;
    logic [TICK_W-1:0] r_tally;
    logic [7:0]        w_byte;
    logic              w_load;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RUN;
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tick  <= w_wrap;
        end
    end

    // Clear outranks enable and wrap; HALT pins the count at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wrap      = 1'b0;
        if (i_clear) begin
            w_state_nxt = RUN;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_enable) begin
                        if (r_count == LP_LAST) begin
                            w_count_nxt = '0;
                            w_wrap      = 1'b1;
                            if (i_oneshot) begin
                                w_state_nxt = HALT;
                            end
                        end else begin
                            w_count_nxt = r_count + WIDTH'(1);
                        end
                    end
                end
                HALT: begin
                    w_count_nxt = '0;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_tally <= '0;
        end else if (i_clear) begin
            r_tally <= '0;
        end else if (w_wrap) begin
            r_tally <= r_tally + TICK_W'(1);
        end
    end

`ifdef PERIODIC_TICK_ASCII_EN
    logic [3:0] r_digit;

    // Tracks the tally mod 10 so the payload needs no divider.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_digit <= 4'd0;
        end else if (i_clear) begin
            r_digit <= 4'd0;
        end else if (w_wrap) begin
            r_digit <= digit_next(r_digit);
        end
    end

    assign w_byte = ASCII_ZERO + {4'd0, r_digit};
`else
    assign w_byte = TICK_CHAR;
`endif

    assign w_load = r_tick & ~i_clear;

    uart_req_slot u_slot (
        .clk         (clk),
        .rst         (i_reset),
        .i_load      (w_load),
        .i_data      (w_byte),
        .i_ready     (i_uart_ready),
        .i_clear_ovr (i_clear),
        .o_valid     (o_start_uart),
        .o_data      (o_uart_data),
        .o_overrun   (o_overrun)
    );

    assign o_count      = r_count;
    assign o_tick       = r_tick;
    assign o_tick_count = r_tally;

endmodule
